// File: rtl/archlearn_pkg.sv
// Shared architecture constants for the archlearn datapath blocks.
// Also holds the max-pool stage FSM encoding and a signed max helper.
package archlearn_pkg;
  localparam int BYTE   = 8;
  localparam int WORD   = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    FIN
  } pool_state_t;

  function automatic logic signed [BYTE-1:0] smax(input logic signed [BYTE-1:0] a,
                                                  input logic signed [BYTE-1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/pool_addr_gen.sv
// Address generator for the 2x2 max-pool stage: oy/ox/c/tap counters, HWC read
// address of the current window tap, HWC write address and last-element flag.
module pool_addr_gen
  import archlearn_pkg::*;
#(
  parameter int DIM_IN  = 32,
  parameter int DIM_OUT = 16,
  parameter int CH      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_active,
  input  logic              tap_adv,
  input  logic              elem_adv,
  output logic [1:0]        tap,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_elem
);
  localparam int OW = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [ADDR_W-1:0] DIN_W  = ADDR_W'(DIM_IN);
  localparam logic [ADDR_W-1:0] DOUT_W = ADDR_W'(DIM_OUT);
  localparam logic [ADDR_W-1:0] CH_W   = ADDR_W'(CH);

  logic [OW-1:0]     oy, ox;
  logic [CW-1:0]     c;
  logic [1:0]        tap_q;
  logic              c_last, ox_last, oy_last;
  logic [ADDR_W-1:0] in_y, in_x, cur_rd, rd_hold;

  assign c_last    = (c == CW'(CH - 1));
  assign ox_last   = (ox == OW'(DIM_OUT - 1));
  assign oy_last   = (oy == OW'(DIM_OUT - 1));
  assign last_elem = c_last && ox_last && oy_last;
  assign tap       = tap_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_q <= '0;
      c     <= '0;
      ox    <= '0;
      oy    <= '0;
    end else begin
      if (tap_adv) tap_q <= tap_q + 2'd1;
      if (elem_adv) begin
        if (c_last) begin
          c <= '0;
          if (ox_last) begin
            ox <= '0;
            oy <= oy_last ? '0 : oy + OW'(1);
          end else begin
            ox <= ox + OW'(1);
          end
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

  // Tap bits append to the output coordinate: {oy,tap[1]} = 2*oy + dy.
  always_comb begin
    in_y    = ADDR_W'({oy, tap_q[1]});
    in_x    = ADDR_W'({ox, tap_q[0]});
    cur_rd  = (in_y * DIN_W + in_x) * CH_W + ADDR_W'(c);
    wr_addr = (ADDR_W'(oy) * DOUT_W + ADDR_W'(ox)) * CH_W + ADDR_W'(c);
    rd_addr = rd_active ? cur_rd : rd_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          rd_hold <= '0;
    else if (rd_active) rd_hold <= cur_rd;
  end
endmodule

// File: rtl/maxpool_stage.sv
// 2x2 stride-2 signed max-pool over an HWC feature map, 6 cycles per output.
// Define POOL_RELU_EN to clamp pooled values at zero before writing.
module maxpool_stage
  import archlearn_pkg::*;
#(
  parameter int DIM_IN = 32,
  parameter int CH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic signed [BYTE-1:0] rd_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic signed [BYTE-1:0] wr_data
);
  localparam int DIM_OUT = DIM_IN / 2;

  pool_state_t            state_q, state_d;
  logic                   tap_adv, elem_adv, last_elem;
  logic [1:0]             tap;
  logic signed [BYTE-1:0] max_q;

  pool_addr_gen #(
    .DIM_IN (DIM_IN),
    .DIM_OUT(DIM_OUT),
    .CH     (CH)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .rd_active(state_q == READ),
    .tap_adv  (tap_adv),
    .elem_adv (elem_adv),
    .tap      (tap),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .last_elem(last_elem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tap_adv  = 1'b0;
    elem_adv = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == FIN);
    wr_en    = (state_q == WRITE);
    case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        tap_adv = 1'b1;
        if (tap == 2'd3) state_d = LAST;
      end
      LAST:  state_d = WRITE;
      WRITE: begin
        elem_adv = 1'b1;
        state_d  = last_elem ? FIN : READ;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so READ tap N sees tap N-1 data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if (state_q == READ && tap == 2'd1) begin
      max_q <= rd_data;
    end else if ((state_q == READ && tap != 2'd0) || state_q == LAST) begin
      max_q <= smax(max_q, rd_data);
    end
  end

`ifdef POOL_RELU_EN
  assign wr_data = max_q[BYTE-1] ? '0 : max_q;
`else
  assign wr_data = max_q;
`endif
endmodule

// File: tb/tb_maxpool_stage.sv
// Directed bench for maxpool_stage: 4x4x1, 32x32x32 and 5x5x2 instances
// sharing one clock and reset, each backed by a 1-cycle-latency memory model.
module tb_maxpool_stage;
  import archlearn_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic startA = 1'b0, busyA, doneA, weA;
  logic [15:0] rdA, waA;
  logic signed [7:0] rdataA = '0, wdA;
  logic signed [7:0] memA [0:15];
  logic signed [7:0] outA [0:15];
  int tagA [0:15];
  int runA = 0, wcntA = 0;

  logic startB = 1'b0, busyB, doneB, weB;
  logic [15:0] rdB, waB, lastB = '0;
  logic signed [7:0] rdataB = '0, wdB;
  logic signed [7:0] memB [0:32767];
  logic signed [7:0] outB [0:8191];
  int tagB [0:8191];
  int runB = 0, wcntB = 0;

  logic startC = 1'b0, busyC, doneC, weC;
  logic [15:0] rdC, waC, lastC = '0;
  logic signed [7:0] rdataC = '0, wdC;
  logic signed [7:0] memC [0:63];
  logic signed [7:0] outC [0:63];
  int tagC [0:63];
  int runC = 0, wcntC = 0, badrdC = 0;

  maxpool_stage #(.DIM_IN(4), .CH(1)) u_a (
    .clk(clk), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .rd_addr(rdA), .rd_data(rdataA), .wr_en(weA), .wr_addr(waA), .wr_data(wdA));
  maxpool_stage #(.DIM_IN(32), .CH(32)) u_b (
    .clk(clk), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .rd_addr(rdB), .rd_data(rdataB), .wr_en(weB), .wr_addr(waB), .wr_data(wdB));
  maxpool_stage #(.DIM_IN(5), .CH(2)) u_c (
    .clk(clk), .reset(reset), .start(startC), .busy(busyC), .done(doneC),
    .rd_addr(rdC), .rd_data(rdataC), .wr_en(weC), .wr_addr(waC), .wr_data(wdC));

  always @(posedge clk) begin
    rdataA <= memA[rdA[3:0]];
    rdataB <= memB[rdB[14:0]];
    rdataC <= memC[rdC[5:0]];
    if (weA) begin
      outA[waA[3:0]] <= wdA;
      tagA[waA[3:0]] <= runA;
      wcntA <= wcntA + 1;
    end
    if (weB) begin
      outB[waB[12:0]] <= wdB;
      tagB[waB[12:0]] <= runB;
      wcntB <= wcntB + 1;
      lastB <= waB;
    end
    if (weC) begin
      outC[waC[5:0]] <= wdC;
      tagC[waC[5:0]] <= runC;
      wcntC <= wcntC + 1;
      lastC <= waC;
    end
    // Pixel index p = addr/CH; x = p%5, y = p/5 must both stay below 4.
    if (busyC && (rdC >= 16'd50 || ((rdC / 2) % 5) == 4 || ((rdC / 2) / 5) == 4))
      badrdC <= badrdC + 1;
  end

  function automatic logic signed [7:0] pat(int a, int seed);
    int v;
    v = (a * 73 + (a / 37) * 29 + seed) & 255;
    return 8'(v);
  endfunction

  function automatic logic signed [7:0] post(logic signed [7:0] v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 8'sd0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [7:0] exp_pool(int dim, int ch, int seed, int oy, int ox, int c);
    logic signed [7:0] m, t;
    m = 8'sh80;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        t = pat(((2 * oy + dy) * dim + 2 * ox + dx) * ch + c, seed);
        if (t > m) m = t;
      end
    return post(m);
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared += 8;
    if (busyB !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busyB); end
    if (doneB !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", doneB); end
    if (weB !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en: got %b expected 0", weB); end
    if (rdB !== 16'd0) begin mismatched++; $display("FAIL reset_rd_addr: got %0d expected 0", rdB); end
    if (waB !== 16'd0) begin mismatched++; $display("FAIL reset_wr_addr: got %0d expected 0", waB); end
    if (wdB !== 8'sd0) begin mismatched++; $display("FAIL reset_wr_data: got %0d expected 0", wdB); end
    if (busyA !== 1'b0) begin mismatched++; $display("FAIL reset_busy_a: got %b expected 0", busyA); end
    if (busyC !== 1'b0) begin mismatched++; $display("FAIL reset_busy_c: got %b expected 0", busyC); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_a(output int n);
    @(negedge clk) startA = 1'b1;
    @(negedge clk) startA = 1'b0;
    n = 1;
    compared++;
    if (busyA !== 1'b1) begin mismatched++; $display("FAIL a_busy_after_start: got %b expected 1", busyA); end
    while (!doneA && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_window();
    int v [16] = '{-5, 3, 10, 2, 7, -1, -8, 4, -20, -20, 0, -128, -20, -20, 127, 5};
    int n, base;
    for (int i = 0; i < 16; i++) memA[i] = 8'(v[i]);
    runA = 1;
    base = wcntA;
    run_a(n);
    compared += 6;
    if (n != 25) begin mismatched++; $display("FAIL a_done_latency: got %0d expected 25", n); end
    if (wcntA - base != 4) begin mismatched++; $display("FAIL a_write_count: got %0d expected 4", wcntA - base); end
    if (tagA[0] != 1 || outA[0] !== 8'sd7)
      begin mismatched++; $display("FAIL a_win0: got %0d expected 7", outA[0]); end
    if (tagA[1] != 1 || outA[1] !== 8'sd10)
      begin mismatched++; $display("FAIL a_win1: got %0d expected 10", outA[1]); end
    if (tagA[2] != 1 || outA[2] !== post(-8'sd20))
      begin mismatched++; $display("FAIL a_win2_neg: got %0d expected %0d", outA[2], post(-8'sd20)); end
    if (tagA[3] != 1 || outA[3] !== 8'sd127)
      begin mismatched++; $display("FAIL a_win3: got %0d expected 127", outA[3]); end
    // start while done is high must be ignored
    startA = 1'b1;
    @(negedge clk) startA = 1'b0;
    compared += 3;
    if (doneA !== 1'b0) begin mismatched++; $display("FAIL a_done_pulse: got %b expected 0", doneA); end
    if (busyA !== 1'b0) begin mismatched++; $display("FAIL a_start_in_fin: got %b expected 0", busyA); end
    @(negedge clk);
    if (busyA !== 1'b0) begin mismatched++; $display("FAIL a_start_in_fin2: got %b expected 0", busyA); end
  endtask

  task automatic test_back_to_back();
    int v [16] = '{-20, -20, -1, -2, -20, -20, -3, 100, -128, -128, 50, -50, -128, -127, 49, 51};
    int n, base;
    for (int i = 0; i < 16; i++) memA[i] = 8'(v[i]);
    runA = 2;
    base = wcntA;
    run_a(n);
    compared += 6;
    if (n != 25) begin mismatched++; $display("FAIL b2b_latency: got %0d expected 25", n); end
    if (wcntA - base != 4) begin mismatched++; $display("FAIL b2b_write_count: got %0d expected 4", wcntA - base); end
    if (tagA[0] != 2 || outA[0] !== post(-8'sd20))
      begin mismatched++; $display("FAIL b2b_all_neg20: got %0d expected %0d", outA[0], post(-8'sd20)); end
    if (tagA[1] != 2 || outA[1] !== 8'sd100)
      begin mismatched++; $display("FAIL b2b_tap3_max: got %0d expected 100", outA[1]); end
    if (tagA[2] != 2 || outA[2] !== post(-8'sd127))
      begin mismatched++; $display("FAIL b2b_near_min: got %0d expected %0d", outA[2], post(-8'sd127)); end
    if (tagA[3] != 2 || outA[3] !== 8'sd51)
      begin mismatched++; $display("FAIL b2b_win3: got %0d expected 51", outA[3]); end
  endtask

  task automatic test_reset_mid_run();
    int base;
    for (int a = 0; a < 32768; a++) memB[a] = pat(a, 11);
    runB = 1;
    @(negedge clk) startB = 1'b1;
    @(negedge clk) startB = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    compared += 6;
    if (busyB !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy: got %b expected 0", busyB); end
    if (doneB !== 1'b0) begin mismatched++; $display("FAIL mid_reset_done: got %b expected 0", doneB); end
    if (weB !== 1'b0) begin mismatched++; $display("FAIL mid_reset_wr_en: got %b expected 0", weB); end
    if (rdB !== 16'd0) begin mismatched++; $display("FAIL mid_reset_rd_addr: got %0d expected 0", rdB); end
    if (waB !== 16'd0) begin mismatched++; $display("FAIL mid_reset_wr_addr: got %0d expected 0", waB); end
    if (wdB !== 8'sd0) begin mismatched++; $display("FAIL mid_reset_wr_data: got %0d expected 0", wdB); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = wcntB;
    repeat (4) @(negedge clk);
    compared += 2;
    if (wcntB - base != 0) begin mismatched++; $display("FAIL post_reset_writes: got %0d expected 0", wcntB - base); end
    if (busyB !== 1'b0) begin mismatched++; $display("FAIL post_reset_busy: got %b expected 0", busyB); end
  endtask

  task automatic test_full_map();
    int n, base, bad, first;
    logic signed [7:0] e, firste;
    runB = 2;
    base = wcntB;
    @(negedge clk) startB = 1'b1;
    @(negedge clk) startB = 1'b0;
    n = 1;
    while (!doneB && n < 60000) begin
      @(negedge clk);
      n++;
    end
    bad = 0;
    first = -1;
    firste = '0;
    for (int oy = 0; oy < 16; oy++)
      for (int ox = 0; ox < 16; ox++)
        for (int c = 0; c < 32; c++) begin
          e = exp_pool(32, 32, 11, oy, ox, c);
          if (tagB[(oy * 16 + ox) * 32 + c] != 2 || outB[(oy * 16 + ox) * 32 + c] !== e) begin
            if (first < 0) begin first = (oy * 16 + ox) * 32 + c; firste = e; end
            bad++;
          end
        end
    compared += 4;
    if (n != 49153) begin mismatched++; $display("FAIL full_done_latency: got %0d expected 49153", n); end
    if (wcntB - base != 8192) begin mismatched++; $display("FAIL full_write_count: got %0d expected 8192", wcntB - base); end
    if (lastB !== 16'd8191) begin mismatched++; $display("FAIL full_last_addr: got %0d expected 8191", lastB); end
    if (bad != 0)
      begin mismatched++; $display("FAIL full_contents: %0d bad, first at %0d got %0d expected %0d", bad, first, outB[first], firste); end
  endtask

  task automatic run_c(input int run, input bit poke, output int n, output int bad, output int writes, output int badrd);
    int base, rbase;
    runC = run;
    base = wcntC;
    rbase = badrdC;
    @(negedge clk) startC = 1'b1;
    @(negedge clk) startC = 1'b0;
    n = 1;
    while (!doneC && n < 500) begin
      if (poke && (n == 10 || n == 24 || n == 47)) startC = 1'b1;
      @(negedge clk);
      startC = 1'b0;
      n++;
    end
    bad = 0;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        for (int c = 0; c < 2; c++)
          if (tagC[(oy * 2 + ox) * 2 + c] != run || outC[(oy * 2 + ox) * 2 + c] !== exp_pool(5, 2, 5, oy, ox, c))
            bad++;
    writes = wcntC - base;
    badrd = badrdC - rbase;
  endtask

  task automatic test_odd_dim();
    int n, bad, writes, badrd;
    for (int a = 0; a < 64; a++) memC[a] = pat(a, 5);
    run_c(1, 1'b0, n, bad, writes, badrd);
    compared += 5;
    if (n != 49) begin mismatched++; $display("FAIL odd_latency: got %0d expected 49", n); end
    if (writes != 8) begin mismatched++; $display("FAIL odd_write_count: got %0d expected 8", writes); end
    if (lastC !== 16'd7) begin mismatched++; $display("FAIL odd_last_addr: got %0d expected 7", lastC); end
    if (badrd != 0) begin mismatched++; $display("FAIL odd_edge_read: got %0d expected 0", badrd); end
    if (bad != 0) begin mismatched++; $display("FAIL odd_contents: got %0d bad expected 0", bad); end
  endtask

  task automatic test_busy_start();
    int n, bad, writes, badrd;
    run_c(2, 1'b1, n, bad, writes, badrd);
    compared += 4;
    if (n != 49) begin mismatched++; $display("FAIL busy_start_latency: got %0d expected 49", n); end
    if (writes != 8) begin mismatched++; $display("FAIL busy_start_writes: got %0d expected 8", writes); end
    if (bad != 0) begin mismatched++; $display("FAIL busy_start_contents: got %0d bad expected 0", bad); end
    @(negedge clk);
    @(negedge clk);
    if (busyC !== 1'b0) begin mismatched++; $display("FAIL busy_start_idle: got %b expected 0", busyC); end
  endtask

  initial begin
    test_reset();
    test_window();
    test_back_to_back();
    test_odd_dim();
    test_busy_start();
    test_reset_mid_run();
    test_full_map();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
